// File: rtl/buffered_uart_rx_pkg.sv
// rtl/buffered_uart_rx_pkg.sv - shared UART receiver/transmitter state encoding and timing helpers
package buffered_uart_rx_pkg;

    // Receiver/transmitter framing states; buffered_uart_tx uses the same encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per bit, truncated toward zero (416 at 48 MHz / 115200).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/buffered_uart_rx_sync_fifo.sv
// rtl/buffered_uart_rx_sync_fifo.sv - show-ahead byte FIFO that drops pushes when full
module buffered_uart_rx_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             overrun
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign do_push  = push && (!full || do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are never reset because empty masks data_out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and the dropped-byte pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overrun <= push && full && !pop;
        end
    end

endmodule

// File: rtl/buffered_uart_rx.sv
// rtl/buffered_uart_rx.sv - 8N1 UART receiver feeding a byte FIFO for the USB bridge
module buffered_uart_rx
    import buffered_uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    input  logic       r_en,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BCNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCNT_W-1:0] FULL_LAST = BCNT_W'(CLKS_PER_BIT - 1);

    uart_state_t            state;
    logic [BCNT_W-1:0]      bcnt;
    logic [2:0]             bidx;
    logic [DATA_BITS-1:0]   shift;
    logic                   sync1;
    logic                   rx_s;
    logic                   push;
    // Set after a bad stop bit so a held-low line (break) cannot retrigger a frame.
    logic                   wait_high;

    // Two-flop synchronizer; the line idles high so the flops reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    // Framing FSM: start-bit qualification at mid-bit, LSB-first data, mid-stop decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bcnt      <= '0;
            bidx      <= '0;
            shift     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
            wait_high <= 1'b0;
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bcnt <= '0;
                    if (wait_high) begin
                        if (rx_s) begin
                            wait_high <= 1'b0;
                        end
                    end else if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bcnt == HALF_LAST) begin
                        bcnt  <= '0;
                        bidx  <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bcnt == FULL_LAST) begin
                        bcnt        <= '0;
                        shift[bidx] <= rx_s;
                        if (bidx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bidx <= bidx + 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bcnt == FULL_LAST) begin
                        bcnt  <= '0;
                        state <= ST_IDLE;
                        if (rx_s) begin
                            push <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    buffered_uart_rx_sync_fifo #(
        .WIDTH      (DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift),
        .pop       (r_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_buffered_uart_rx.sv
// tb/tb_buffered_uart_rx.sv - directed bench for buffered_uart_rx
module tb_buffered_uart_rx;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 16;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] data_out;
    logic       r_en;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       frame_err;

    int pass_cnt;
    int total_cnt;
    int fe_cnt;
    int ov_cnt;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
    } vec_t;

    vec_t vecs [7];
    logic [7:0] model [$];

    buffered_uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .data_out  (data_out),
        .r_en      (r_en),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun)   ov_cnt = ov_cnt + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Called on a negedge; each bit held for CPB negedges, returns on a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic pop_byte();
        r_en = 1'b1;
        @(negedge clk);
        r_en = 1'b0;
    endtask

    initial begin
        int fe0;
        int ov0;
        logic [7:0] exp_b;
        pass_cnt  = 0;
        total_cnt = 0;
        fe_cnt    = 0;
        ov_cnt    = 0;
        uart_rx   = 1'b1;
        r_en      = 1'b0;
        rst       = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h55, 1'b0, 1'b0};
        vecs[2] = '{8'h12, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_data_out", data_out, 8'h00);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Table: single frames with good and bad stop bits
        for (int v = 0; v < 7; v++) begin
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            repeat (CPB) @(negedge clk);
            check("vec_frame_err", fe_cnt - fe0, vecs[v].exp_push ? 0 : 1);
            check("vec_empty", empty, !vecs[v].exp_push);
            if (vecs[v].exp_push) begin
                check("vec_data", data_out, vecs[v].data);
                pop_byte();
                check("vec_empty_after_pop", empty, 1);
            end
        end

        // Pop while empty has no effect
        pop_byte();
        check("pop_empty_empty", empty, 1);
        check("pop_empty_full", full, 0);

        // Reset mid-frame: queued byte cleared, partial frame discarded
        send_frame(8'h77, 1'b1);
        check("pre_rst_data", data_out, 8'h77);
        fe0 = fe_cnt;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (52) @(negedge clk);
                #3 rst = 1'b0;
                #1;
                check("midrst_empty", empty, 1);
                check("midrst_data_out", data_out, 8'h00);
                check("midrst_full", full, 0);
                check("midrst_frame_err", frame_err, 0);
                repeat (36) @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (2 * CPB) @(negedge clk);
        check("post_rst_empty", empty, 1);
        check("post_rst_no_fe", fe_cnt - fe0, 0);

        // Burst of 16 fills the FIFO
        ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        check("burst_full", full, 1);
        check("burst_no_overrun", ov_cnt - ov0, 0);

        // Overrun: byte dropped, contents unchanged
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        check("overrun_pulses", ov_cnt - ov0, 1);
        check("overrun_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            check("overrun_drain", data_out, 8'(i));
            pop_byte();
        end
        check("drain_empty", empty, 1);

        // Push and pop in the same cycle while full: no overrun
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (155) @(negedge clk);
                r_en = 1'b1;
                @(negedge clk);
                r_en = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("pushpop_full_no_overrun", ov_cnt - ov0, 0);
        check("pushpop_full_still_full", full, 1);
        for (int i = 1; i < 17; i++) begin
            exp_b = (i == 16) ? 8'h3C : 8'(i);
            check("pushpop_drain", data_out, exp_b);
            pop_byte();
        end
        check("pushpop_empty", empty, 1);

        // Glitch shorter than half a bit is rejected
        fe0 = fe_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_empty", empty, 1);
        send_frame(8'h5A, 1'b1);
        check("glitch_then_byte", data_out, 8'h5A);
        pop_byte();

        // Break: one frame error only, then recovery
        fe0 = fe_cnt;
        uart_rx = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break_one_fe", fe_cnt - fe0, 1);
        check("break_empty", empty, 1);
        send_frame(8'hC3, 1'b1);
        check("break_then_byte", data_out, 8'hC3);
        pop_byte();

        // Wrap: 8 bytes queued, one pop per arriving byte, 40 arrivals
        model.delete();
        ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1);
            model.push_back(8'h40 + 8'(i));
        end
        for (int i = 0; i < 40; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1);
            model.push_back(8'h80 + 8'(i));
            exp_b = model.pop_front();
            check("wrap_order", data_out, exp_b);
            pop_byte();
        end
        while (model.size() > 0) begin
            exp_b = model.pop_front();
            check("wrap_tail", data_out, exp_b);
            pop_byte();
        end
        check("wrap_empty", empty, 1);
        check("wrap_no_overrun", ov_cnt - ov0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
